pin_auth_ctrl: RTL and testbench
================================

// Module: pin_auth_ctrl
// PURPOSE
//  Sequences the wallet PIN flow: enrolment (enter + confirm), verification, failed-try counting,
//  timed lockout and wipe after too many failures. Builds PINs from the two-button UI
//  (b_dir_i = next digit, b_esq_i = select) and drives the secure-storage write plus the unlock gate.
// PARAMETERS
//  DIGITS     4     PIN length in digits; PIN_W = 4*DIGITS
//  MAX_TRIES  3     consecutive verify failures before wipe (>=1)
//  LOCK_CYC   1000  lockout length in clk_i cycles after a non-final failure (>=1)
// PORTS
//  clk_i         in   1      single clock, rising edge
//  rst_n_i       in   1      synchronous, active-low reset
//  b_esq_i       in   1      select button, debounced, synchronous level
//  b_dir_i       in   1      increment button, debounced, synchronous level
//  start_i       in   1      request verify session (honoured only in READY)
//  abort_i       in   1      abandon current entry
//  lock_i        in   1      relock from UNLOCKED
//  digit_o       out  4      digit under cursor, 0..9
//  idx_o         out  2      cursor position (digit index being entered)
//  state_o       out  3      current state encoding (pin_pkg)
//  tries_left_o  out  2      remaining verify attempts
//  unlock_o      out  1      level, high only in UNLOCKED
//  fail_o        out  1      1-cycle pulse per verify failure
//  pin_wr_o      out  1      1-cycle pulse: pin_vec_o valid for storage
//  pin_vec_o     out  PIN_W  enrolled PIN; digit k at [4k+3:4k] (first entered = [3:0])
//  wipe_o        out  1      1-cycle pulse: erase keys/PIN
// BEHAVIOUR
//  Reset: state UNENROLLED, digit/idx/stored PIN/outputs 0, tries_left_o=MAX_TRIES, prev-button regs=1
//   (a button held through reset fires only after release and re-press).
//  Edges: press = level & ~prev. b_dir press: digit+1, 9 wraps to 0. b_esq press: write digit to
//   slot idx, digit<=0, idx+1. Same-cycle b_esq+b_dir: select wins, increment dropped.
//   Presses ignored outside ENTRY states.
//  States: UNENROLLED, ENR_A, ENR_B, READY, VERIFY, CHECK, UNLOCKED, LOCKOUT (WIPE = 1-cycle transient).
//  UNENROLLED -> ENR_A on first press of either button (that press is consumed, no digit effect).
//  ENR_A: DIGITS selects latch candidate -> ENR_B (idx/digit cleared).
//  ENR_B: DIGITS selects -> compare with candidate: match -> pin_wr_o pulse, pin_vec_o=candidate,
//   READY; mismatch -> ENR_A, candidate cleared, no try consumed.
//  READY: start_i -> VERIFY. VERIFY: DIGITS selects -> CHECK (1 cycle, compare vs stored PIN).
//  CHECK match -> UNLOCKED, tries_left=MAX_TRIES. Mismatch -> fail_o pulse, tries_left-1;
//   if it reaches 0 -> WIPE: wipe_o pulse, stored PIN=0, tries=MAX_TRIES, next UNENROLLED;
//   else LOCKOUT, counter loaded LOCK_CYC-1, READY after exactly LOCK_CYC cycles.
//  Latency: final select at edge N -> CHECK in cycle N+1 -> unlock_o/fail_o/wipe_o valid from N+2.
//  UNLOCKED: lock_i -> READY, unlock_o low next cycle. start_i ignored.
//  abort_i: ENR_A/ENR_B -> UNENROLLED; VERIFY -> READY; idx/digit cleared; no try consumed;
//   ignored in CHECK, LOCKOUT, UNLOCKED. abort_i beats a same-cycle select.
//  Reset mid-operation: full return to reset values; stored PIN lost (persistence is storage's job).
//  All outputs registered; pulses never exceed one cycle.
// STRUCTURE
//  pin_pkg: state enum/encoding, DIG_W=4, DIG_MAX=9, pin field slice helper.
//  Sub-module pin_entry: edge detect, digit/idx counters, entry shift slots, done pulse; shared by
//   enrol and verify; clear input from controller. Top holds FSM, tries, lockout counter, storage reg.
// TESTING
//  Enrol 3210 (0;R,S;RR,S;RRR,S) twice -> pin_wr_o 1 pulse, pin_vec_o=16'h3210, state READY.
//  Enrol 3210 then confirm 3211 -> no pin_wr_o, back to ENR_A, tries_left_o=3.
//  start_i, enter 3210 -> unlock_o high 2 cycles after final select; lock_i -> unlock_o low next cycle.
//  Three wrong PINs (LOCK_CYC=8) -> fail_o x3, LOCKOUT held exactly 8 cycles twice, wipe_o pulse,
//   pin_vec_o=0, state UNENROLLED.
//  10 b_dir presses -> digit_o 0; b_esq+b_dir same cycle -> digit committed, no increment.
//  rst_n_i low mid-VERIFY with b_esq_i held -> reset values; no select until re-press; abort_i mid-entry -> READY.

Source files
------------

// File: rtl/pin_pkg.sv
// Shared types and helpers for the wallet PIN controller.
// State encoding, digit constants and PIN field helpers.
package pin_pkg;

  localparam int DIG_W = 4;
  localparam int IDX_W = 2;
  localparam logic [DIG_W-1:0] DIG_MAX = 4'd9;

  typedef enum logic [2:0] {
    ST_UNENROLLED = 3'd0,
    ST_ENR_A      = 3'd1,
    ST_ENR_B      = 3'd2,
    ST_READY      = 3'd3,
    ST_VERIFY     = 3'd4,
    ST_CHECK      = 3'd5,
    ST_UNLOCKED   = 3'd6,
    ST_LOCKOUT    = 3'd7
  } state_e;

  // Bit offset of digit slot k inside a packed PIN.
  function automatic int pin_lsb(input int k);
    return k * DIG_W;
  endfunction

  function automatic logic [DIG_W-1:0] dig_inc(
    input logic [DIG_W-1:0] d
  );
    return (d == DIG_MAX) ? '0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/pin_entry.sv
// Two-button PIN entry: edge detect, digit/cursor counters, slots.
// Shared by enrolment and verification; cleared by the controller.
module pin_entry
  import pin_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      b_esq_i,
  input  logic                      b_dir_i,
  input  logic                      en_i,
  input  logic                      clr_i,
  output logic [DIG_W-1:0]          digit_o,
  output logic [IDX_W-1:0]          idx_o,
  output logic [DIGITS*DIG_W-1:0]   pin_o,
  output logic [DIGITS*DIG_W-1:0]   pin_nxt_o,
  output logic                      press_o,
  output logic                      done_o
);

  localparam int PIN_W = DIGITS * DIG_W;

  logic             esq_prev_q, dir_prev_q;
  logic             esq_p, dir_p, sel, inc, last;
  logic [DIG_W-1:0] digit_q, digit_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [PIN_W-1:0] pin_q, pin_d;

  assign esq_p = b_esq_i & ~esq_prev_q;
  assign dir_p = b_dir_i & ~dir_prev_q;
  assign sel   = en_i & esq_p;
  // Select wins over a same-cycle increment.
  assign inc   = en_i & dir_p & ~esq_p;
  assign last  = (idx_q == IDX_W'(DIGITS - 1));

  always_comb begin
    digit_d = digit_q;
    idx_d   = idx_q;
    pin_d   = pin_q;
    if (clr_i) begin
      digit_d = '0;
      idx_d   = '0;
      pin_d   = '0;
    end else if (sel) begin
      pin_d[pin_lsb(int'(idx_q)) +: DIG_W] = digit_q;
      digit_d = '0;
      idx_d   = last ? '0 : idx_q + 1'b1;
    end else if (inc) begin
      digit_d = dig_inc(digit_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      esq_prev_q <= 1'b1;
      dir_prev_q <= 1'b1;
      digit_q    <= '0;
      idx_q      <= '0;
      pin_q      <= '0;
    end else begin
      esq_prev_q <= b_esq_i;
      dir_prev_q <= b_dir_i;
      digit_q    <= digit_d;
      idx_q      <= idx_d;
      pin_q      <= pin_d;
    end
  end

  assign digit_o   = digit_q;
  assign idx_o     = idx_q;
  assign pin_o     = pin_q;
  assign pin_nxt_o = pin_d;
  assign press_o   = esq_p | dir_p;
  assign done_o    = sel & last;

endmodule

// File: rtl/pin_auth_ctrl.sv
// Wallet PIN flow: enrolment, verification, try counting,
// timed lockout and wipe. Entry datapath lives in pin_entry.
module pin_auth_ctrl
  import pin_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int MAX_TRIES = 3,
  parameter int LOCK_CYC  = 1000,
  localparam int PIN_W    = 4 * DIGITS
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             b_esq_i,
  input  logic             b_dir_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             lock_i,
  output logic [3:0]       digit_o,
  output logic [1:0]       idx_o,
  output logic [2:0]       state_o,
  output logic [1:0]       tries_left_o,
  output logic             unlock_o,
  output logic             fail_o,
  output logic             pin_wr_o,
  output logic [PIN_W-1:0] pin_vec_o,
  output logic             wipe_o
);

  localparam int CW = (LOCK_CYC > 1) ? $clog2(LOCK_CYC) : 1;
  localparam logic [1:0] TRIES_MAX = 2'(MAX_TRIES);

  state_e           state_q, state_d;
  logic [1:0]       tries_q, tries_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PIN_W-1:0] cand_q, cand_d;
  logic [PIN_W-1:0] pin_q, pin_d;
  logic             unlock_q, fail_q, fail_d;
  logic             wr_q, wr_d, wipe_q, wipe_d;

  logic             en, clr, press, done;
  logic [PIN_W-1:0] ent_pin, ent_nxt;

  assign en = (state_q inside {ST_ENR_A, ST_ENR_B, ST_VERIFY});

  pin_entry #(
    .DIGITS (DIGITS)
  ) u_entry (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .b_esq_i   (b_esq_i),
    .b_dir_i   (b_dir_i),
    .en_i      (en),
    .clr_i     (clr),
    .digit_o   (digit_o),
    .idx_o     (idx_o),
    .pin_o     (ent_pin),
    .pin_nxt_o (ent_nxt),
    .press_o   (press),
    .done_o    (done)
  );

  always_comb begin
    state_d = state_q;
    tries_d = tries_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    pin_d   = pin_q;
    fail_d  = 1'b0;
    wipe_d  = 1'b0;
    wr_d    = 1'b0;
    clr     = 1'b0;
    unique case (state_q)
      ST_UNENROLLED: begin
        if (press) begin
          state_d = ST_ENR_A;
          clr     = 1'b1;
        end
      end
      ST_ENR_A: begin
        if (abort_i) begin
          state_d = ST_UNENROLLED;
          clr     = 1'b1;
          cand_d  = '0;
        end else if (done) begin
          cand_d  = ent_nxt;
          state_d = ST_ENR_B;
        end
      end
      ST_ENR_B: begin
        if (abort_i) begin
          state_d = ST_UNENROLLED;
          clr     = 1'b1;
          cand_d  = '0;
        end else if (done) begin
          if (ent_nxt == cand_q) begin
            wr_d    = 1'b1;
            pin_d   = cand_q;
            state_d = ST_READY;
          end else begin
            cand_d  = '0;
            state_d = ST_ENR_A;
          end
        end
      end
      ST_READY: begin
        if (start_i) begin
          state_d = ST_VERIFY;
          clr     = 1'b1;
        end
      end
      ST_VERIFY: begin
        if (abort_i) begin
          state_d = ST_READY;
          clr     = 1'b1;
        end else if (done) begin
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (ent_pin == pin_q) begin
          state_d = ST_UNLOCKED;
          tries_d = TRIES_MAX;
        end else begin
          fail_d = 1'b1;
          // Last allowed failure wipes instead of locking out.
          if (tries_q == 2'd1) begin
            wipe_d  = 1'b1;
            pin_d   = '0;
            cand_d  = '0;
            tries_d = TRIES_MAX;
            state_d = ST_UNENROLLED;
          end else begin
            tries_d = tries_q - 2'd1;
            cnt_d   = CW'(LOCK_CYC - 1);
            state_d = ST_LOCKOUT;
          end
        end
      end
      ST_UNLOCKED: begin
        if (lock_i) state_d = ST_READY;
      end
      ST_LOCKOUT: begin
        if (cnt_q == '0) state_d = ST_READY;
        else             cnt_d   = cnt_q - 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_UNENROLLED;
      tries_q  <= TRIES_MAX;
      cnt_q    <= '0;
      cand_q   <= '0;
      pin_q    <= '0;
      unlock_q <= 1'b0;
      fail_q   <= 1'b0;
      wr_q     <= 1'b0;
      wipe_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tries_q  <= tries_d;
      cnt_q    <= cnt_d;
      cand_q   <= cand_d;
      pin_q    <= pin_d;
      unlock_q <= (state_d == ST_UNLOCKED);
      fail_q   <= fail_d;
      wr_q     <= wr_d;
      wipe_q   <= wipe_d;
    end
  end

  assign state_o      = state_q;
  assign tries_left_o = tries_q;
  assign unlock_o     = unlock_q;
  assign fail_o       = fail_q;
  assign pin_wr_o     = wr_q;
  assign pin_vec_o    = pin_q;
  assign wipe_o       = wipe_q;

endmodule

// File: tb/tb_pin_auth_ctrl.sv
// Directed bench for pin_auth_ctrl: enrol, verify, lockout,
// wipe, button edge rules, abort and mid-operation reset.
module tb_pin_auth_ctrl;

  localparam int DIGITS = 4;
  localparam int PIN_W  = 16;

  localparam logic [2:0] S_UNE = 3'd0;
  localparam logic [2:0] S_ENA = 3'd1;
  localparam logic [2:0] S_ENB = 3'd2;
  localparam logic [2:0] S_RDY = 3'd3;
  localparam logic [2:0] S_VER = 3'd4;
  localparam logic [2:0] S_CHK = 3'd5;
  localparam logic [2:0] S_UNL = 3'd6;
  localparam logic [2:0] S_LCK = 3'd7;

  logic             clk = 1'b0;
  logic             rst_n, b_esq, b_dir, start, abort_s, lock;
  logic [3:0]       digit;
  logic [1:0]       idx;
  logic [2:0]       state;
  logic [1:0]       tries;
  logic             unlock, fail, pin_wr, wipe;
  logic [PIN_W-1:0] pin_vec;

  int errors = 0;
  int checks = 0;
  int n_wr = 0, n_fail = 0, n_wipe = 0;
  logic [2:0] st_n1;
  logic       unl_n1;

  always #5 clk = ~clk;

  pin_auth_ctrl #(
    .DIGITS    (DIGITS),
    .MAX_TRIES (3),
    .LOCK_CYC  (8)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .b_esq_i      (b_esq),
    .b_dir_i      (b_dir),
    .start_i      (start),
    .abort_i      (abort_s),
    .lock_i       (lock),
    .digit_o      (digit),
    .idx_o        (idx),
    .state_o      (state),
    .tries_left_o (tries),
    .unlock_o     (unlock),
    .fail_o       (fail),
    .pin_wr_o     (pin_wr),
    .pin_vec_o    (pin_vec),
    .wipe_o       (wipe)
  );

  always @(posedge clk) begin
    if (pin_wr) n_wr++;
    if (fail)   n_fail++;
    if (wipe)   n_wipe++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic p_dir();
    b_dir = 1'b1; tick();
    b_dir = 1'b0; tick();
  endtask

  task automatic p_sel();
    b_esq = 1'b1; tick();
    b_esq = 1'b0; tick();
  endtask

  // Enter a full PIN; samples state/unlock right after the final select edge.
  task automatic enter(input logic [PIN_W-1:0] pin);
    logic [3:0] d;
    for (int k = 0; k < DIGITS; k++) begin
      d = pin[4*k +: 4];
      for (int r = 0; r < int'(d); r++) p_dir();
      b_esq = 1'b1; tick();
      st_n1  = state;
      unl_n1 = unlock;
      b_esq = 1'b0; tick();
    end
  endtask

  task automatic do_start();
    start = 1'b1; tick();
    start = 1'b0;
  endtask

  task automatic lockout_len(input string tag);
    int cnt;
    cnt = 0;
    while (state == S_LCK && cnt < 100) begin
      cnt++;
      tick();
    end
    chk(tag, cnt, 8);
    chk({tag, "_rdy"}, state, S_RDY);
  endtask

  initial begin
    rst_n = 1'b0; b_esq = 1'b0; b_dir = 1'b0;
    start = 1'b0; abort_s = 1'b0; lock = 1'b0;
    tick(); tick();
    chk("rst_state", state, S_UNE);
    chk("rst_tries", tries, 3);
    chk("rst_digit", digit, 0);
    chk("rst_idx", idx, 0);
    chk("rst_unlock", unlock, 0);
    chk("rst_pinvec", pin_vec, 0);
    rst_n = 1'b1; tick();

    // Wake press is consumed
    p_dir();
    chk("wake_state", state, S_ENA);
    chk("wake_digit", digit, 0);

    repeat (9) p_dir();
    chk("dig9", digit, 9);
    p_dir();
    chk("dig_wrap", digit, 0);
    chk("dig_wrap_idx", idx, 0);

    // Enrol mismatch
    enter(16'h3210);
    chk("enrA_state", state, S_ENB);
    chk("enrA_idx", idx, 0);
    enter(16'h3211);
    chk("mism_state", state, S_ENA);
    chk("mism_wr", n_wr, 0);
    chk("mism_tries", tries, 3);

    // Enrol match
    enter(16'h3210);
    enter(16'h3210);
    chk("enr_wr", n_wr, 1);
    chk("enr_pin", pin_vec, 16'h3210);
    chk("enr_state", state, S_RDY);

    // Correct verify
    do_start(); tick();
    chk("ver_state", state, S_VER);
    enter(16'h3210);
    chk("ver_chk_n1", st_n1, S_CHK);
    chk("ver_unl_n1", unl_n1, 0);
    chk("ver_unlock", unlock, 1);
    chk("ver_state2", state, S_UNL);
    do_start(); tick();
    chk("unl_start_ign", state, S_UNL);
    lock = 1'b1; tick(); lock = 1'b0;
    chk("lock_unl", unlock, 0);
    chk("lock_state", state, S_RDY);

    // Simultaneous select + increment, then abort
    do_start(); tick();
    p_dir(); p_dir();
    b_esq = 1'b1; b_dir = 1'b1; tick();
    b_esq = 1'b0; b_dir = 1'b0; tick();
    chk("both_digit", digit, 0);
    chk("both_idx", idx, 1);
    p_dir();
    abort_s = 1'b1; tick(); abort_s = 1'b0;
    chk("abort_state", state, S_RDY);
    chk("abort_idx", idx, 0);
    chk("abort_digit", digit, 0);
    chk("abort_tries", tries, 3);

    // Three wrong PINs
    do_start(); tick();
    enter(16'h1111);
    chk("f1_fail", fail, 1);
    chk("f1_state", state, S_LCK);
    chk("f1_tries", tries, 2);
    lockout_len("lock1");
    do_start(); tick();
    enter(16'h0000);
    chk("f2_tries", tries, 1);
    lockout_len("lock2");
    do_start(); tick();
    enter(16'h2310);
    chk("f3_wipe", wipe, 1);
    chk("f3_state", state, S_UNE);
    chk("f3_pin", pin_vec, 0);
    chk("f3_tries", tries, 3);
    tick();
    chk("f3_nfail", n_fail, 3);
    chk("f3_nwipe", n_wipe, 1);

    // Re-enrol, then reset mid-verify with select held
    p_sel();
    chk("re_wake", state, S_ENA);
    enter(16'h3210);
    enter(16'h3210);
    chk("re_wr", n_wr, 2);
    do_start(); tick();
    p_dir();
    b_esq = 1'b1;
    rst_n = 1'b0; tick(); tick();
    rst_n = 1'b1; tick(); tick();
    chk("mr_state", state, S_UNE);
    chk("mr_pin", pin_vec, 0);
    chk("mr_digit", digit, 0);
    chk("mr_tries", tries, 3);
    b_esq = 1'b0; tick();
    chk("mr_release", state, S_UNE);
    b_esq = 1'b1; tick();
    b_esq = 1'b0;
    chk("mr_repress", state, S_ENA);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
